dm_hart_status: RTL and testbench
=================================

# dm_hart_status

Per-hart run-control state tracker for the debug module, generalising the single-hart halted/resuming/going bookkeeping to `NrHarts` harts with hart-array-window selection. It sits between the DM CSR file (dmcontrol writes, dmstatus reads) and the debug-memory flag decoder (hart writes to HALTED/RESUMING/EXCEPTION). It holds per-hart haltreq, resume-pending, halted, resumeack and havereset state. It produces the dmstatus any/all summary bits for the current selection.

## Interface
Parameters:
- `NrHarts`, default 4: number of harts; 1..1024.
- `SelectableHarts`, default `{NrHarts{1'b1}}`: mask of harts that may be selected; unselectable harts are never requested.
- `HartIdBits`, default `(NrHarts>1)?$clog2(NrHarts):1`: width of the hart-side id buses.

Ports:
- `clk_i`, in, 1: clock. One clock domain only.
- `rst_ni`, in, 1: reset, synchronous and active-low.
- `dmactive_i`, in, 1: DM active. Low acts as a soft clear (see Operation).
- `ndmreset_i`, in, 1: non-debug-module reset in progress.
- `unavailable_i`, in, NrHarts: per-hart unavailable flag.
- `hartsel_i`, in, 20: dmcontrol.hartsel (hi:lo concatenated).
- `hasel_i`, in, 1: hart-array mode enable.
- `hawindow_i`, in, NrHarts: hart array window mask.
- `dmcontrol_we_i`, in, 1: single-cycle strobe for a dmcontrol write.
- `haltreq_wdata_i`, in, 1: written haltreq bit.
- `resumereq_wdata_i`, in, 1: written resumereq bit.
- `ackhavereset_wdata_i`, in, 1: written ackhavereset bit.
- `halted_valid_i`, in, 1: hart wrote HALTED.
- `halted_id_i`, in, HartIdBits: id of the hart that wrote HALTED.
- `resuming_valid_i`, in, 1: hart wrote RESUMING.
- `resuming_id_i`, in, HartIdBits: id of the hart that wrote RESUMING.
- `haltreq_o`, out, NrHarts: per-hart halt request.
- `resumereq_o`, out, NrHarts: per-hart resume-pending flag (drives the debug-ROM "go resume" flag).
- `halted_o`, out, NrHarts: per-hart halted state.
- `resumeack_o`, out, NrHarts: per-hart resumeack.
- `havereset_o`, out, NrHarts: per-hart havereset.
- `sel_o`, out, NrHarts: effective selection mask.
- `status_o`, out, 12: {allhavereset, anyhavereset, allresumeack, anyresumeack, allnonexistent, anynonexistent, allunavail, anyunavail, allrunning, anyrunning, allhalted, anyhalted}, MSB first.

## Operation
- **Selection (combinational):**
  - `onehot = (hartsel_i < NrHarts) ? 1<<hartsel_i : 0`.
  - `sel_o = (onehot | (hasel_i ? hawindow_i : 0)) & SelectableHarts`.
  - nonexistent = `hartsel_i >= NrHarts` (computed on hartsel only).
- **dmcontrol write** (`dmcontrol_we_i`), applied to each hart h with `sel_o[h]`:
  - `haltreq[h] <= haltreq_wdata_i`.
  - If `resumereq_wdata_i & ~haltreq_wdata_i & halted[h]`: `resumereq[h] <= 1`, `resumeack[h] <= 0`. Otherwise resumereq for that hart is ignored.
  - If `ackhavereset_wdata_i`: `havereset[h] <= 0`.
  - Unselected harts are unchanged.
- **Hart events** (ids >= NrHarts are ignored):
  - HALTED id h: `halted[h] <= 1`.
  - RESUMING id h: `halted[h] <= 0`, `resumereq[h] <= 0`, `resumeack[h] <= 1`.
- **Priority** (same hart, same cycle):
  - RESUMING event > HALTED event > dmcontrol write resumereq.
  - A write's haltreq/ackhavereset fields still apply alongside events.
- **ndmreset_i high** (every cycle):
  - halted, resumereq, resumeack <= 0.
  - havereset <= all ones.
  - Hart events are ignored.
  - haltreq is retained, so harts halt out of reset.
- **dmactive_i low** (and not ndmreset):
  - haltreq, resumereq, resumeack <= 0.
  - halted and havereset are retained.
  - dmcontrol writes are ignored.
- **Summaries** are over the selected set S = `sel_o`. If S is empty, all any* = 0 and all* = 0, except that nonexistent drives anynonexistent and allnonexistent.
  - running = `~halted & ~unavailable`.
  - any = OR over S; all = AND over S.

## Timing
- Reset (`rst_ni` low at a clock edge): haltreq_o = 0, resumereq_o = 0, halted_o = 0, resumeack_o = 0, havereset_o = all ones. `sel_o` and `status_o` follow from these state values and the current inputs.
- All state updates are registered with one-cycle latency: a strobe at edge N is visible on outputs after edge N.
- `sel_o` and `status_o` are combinational from registered state and current inputs. There is no extra latency.
- Reset wins over `ndmreset_i` and `dmactive_i`.
- `resumereq_o[h]` stays high from the write until the RESUMING event for h, or until a clear (ndmreset, dmactive low, reset).

## Test plan
- **Reset:** NrHarts=4, reset 2 cycles then release, hartsel=0 -> havereset_o=4'b1111, halted_o=0, status anyhavereset=allhavereset=1, allrunning=1.
- **Window halt/resume:** hasel=1, hawindow=4'b0110, hartsel=0, write haltreq=1 -> haltreq_o=4'b0111. Halted events for ids 0,1,2 -> allhalted=1. Write resumereq=1, haltreq=0 -> resumereq_o=4'b0111, resumeack_o=0. RESUMING events for 0,1,2 -> resumereq_o=0, allresumeack=1.
- **Resume while running:** hart 3 not halted, hartsel=3, write resumereq=1 -> resumereq_o[3]=0, resumeack_o unchanged.
- **Simultaneous:** HALTED id 1 and RESUMING id 1 in the same cycle -> halted_o[1]=0, resumeack_o[1]=1.
- **Nonexistent:** hartsel=7, hasel=0 -> sel_o=0, status = only anynonexistent=allnonexistent=1. A write with haltreq=1 changes nothing.
- **ndmreset:** pulse ndmreset_i with hart 2 halted and haltreq set -> halted_o[2]=0, havereset_o=4'b1111, haltreq_o[2] still 1. ackhavereset with hartsel=2 -> havereset_o=4'b1011.

Source files
------------

// File: rtl/dm_hart_status.sv
// Per-hart run-control bookkeeping for the debug module: haltreq, resume-pending,
// halted, resumeack and havereset per hart, plus dmstatus any/all summaries.

module dm_hart_status_lane (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic ndmreset_i,
    input  logic dmactive_i,
    input  logic wr_i,
    input  logic haltreq_wdata_i,
    input  logic resumereq_wdata_i,
    input  logic ackhavereset_wdata_i,
    input  logic halted_ev_i,
    input  logic resuming_ev_i,
    output logic haltreq_o,
    output logic resumereq_o,
    output logic halted_o,
    output logic resumeack_o,
    output logic havereset_o
);
    logic haltreq_q, haltreq_d;
    logic resumereq_q, resumereq_d;
    logic halted_q, halted_d;
    logic resumeack_q, resumeack_d;
    logic havereset_q, havereset_d;

    always_comb begin
        haltreq_d   = haltreq_q;
        resumereq_d = resumereq_q;
        halted_d    = halted_q;
        resumeack_d = resumeack_q;
        havereset_d = havereset_q;
        if (ndmreset_i) begin
            // haltreq survives so the hart halts straight out of reset
            halted_d    = 1'b0;
            resumereq_d = 1'b0;
            resumeack_d = 1'b0;
            havereset_d = 1'b1;
        end else if (!dmactive_i) begin
            haltreq_d   = 1'b0;
            resumereq_d = 1'b0;
            resumeack_d = 1'b0;
        end else begin
            if (wr_i) begin
                haltreq_d = haltreq_wdata_i;
                if (ackhavereset_wdata_i) havereset_d = 1'b0;
            end
            if (resuming_ev_i) begin
                halted_d    = 1'b0;
                resumereq_d = 1'b0;
                resumeack_d = 1'b1;
            end else if (halted_ev_i) begin
                halted_d = 1'b1;
            end else if (wr_i && resumereq_wdata_i && !haltreq_wdata_i && halted_q) begin
                resumereq_d = 1'b1;
                resumeack_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            haltreq_q   <= 1'b0;
            resumereq_q <= 1'b0;
            halted_q    <= 1'b0;
            resumeack_q <= 1'b0;
            havereset_q <= 1'b1;
        end else begin
            haltreq_q   <= haltreq_d;
            resumereq_q <= resumereq_d;
            halted_q    <= halted_d;
            resumeack_q <= resumeack_d;
            havereset_q <= havereset_d;
        end
    end

    assign haltreq_o   = haltreq_q;
    assign resumereq_o = resumereq_q;
    assign halted_o    = halted_q;
    assign resumeack_o = resumeack_q;
    assign havereset_o = havereset_q;
endmodule

module dm_hart_status #(
    parameter int                  NrHarts         = 4,
    parameter logic [NrHarts-1:0]  SelectableHarts = {NrHarts{1'b1}},
    parameter int                  HartIdBits      = (NrHarts > 1) ? $clog2(NrHarts) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  dmactive_i,
    input  logic                  ndmreset_i,
    input  logic [NrHarts-1:0]    unavailable_i,
    input  logic [19:0]           hartsel_i,
    input  logic                  hasel_i,
    input  logic [NrHarts-1:0]    hawindow_i,
    input  logic                  dmcontrol_we_i,
    input  logic                  haltreq_wdata_i,
    input  logic                  resumereq_wdata_i,
    input  logic                  ackhavereset_wdata_i,
    input  logic                  halted_valid_i,
    input  logic [HartIdBits-1:0] halted_id_i,
    input  logic                  resuming_valid_i,
    input  logic [HartIdBits-1:0] resuming_id_i,
    output logic [NrHarts-1:0]    haltreq_o,
    output logic [NrHarts-1:0]    resumereq_o,
    output logic [NrHarts-1:0]    halted_o,
    output logic [NrHarts-1:0]    resumeack_o,
    output logic [NrHarts-1:0]    havereset_o,
    output logic [NrHarts-1:0]    sel_o,
    output logic [11:0]           status_o
);
    localparam logic [19:0] NrHartsW = 20'(NrHarts);

    logic [NrHarts-1:0] onehot;
    logic [NrHarts-1:0] running;
    logic               nonexistent;
    logic               any_sel;

    // Ids that do not match any lane (>= NrHarts) simply decode to nothing.
    for (genvar h = 0; h < NrHarts; h++) begin : g_hart
        assign onehot[h] = (hartsel_i == 20'(h));

        dm_hart_status_lane u_lane (
            .clk_i                (clk_i),
            .rst_ni               (rst_ni),
            .ndmreset_i           (ndmreset_i),
            .dmactive_i           (dmactive_i),
            .wr_i                 (dmcontrol_we_i & sel_o[h]),
            .haltreq_wdata_i      (haltreq_wdata_i),
            .resumereq_wdata_i    (resumereq_wdata_i),
            .ackhavereset_wdata_i (ackhavereset_wdata_i),
            .halted_ev_i          (halted_valid_i && (halted_id_i == HartIdBits'(h))),
            .resuming_ev_i        (resuming_valid_i && (resuming_id_i == HartIdBits'(h))),
            .haltreq_o            (haltreq_o[h]),
            .resumereq_o          (resumereq_o[h]),
            .halted_o             (halted_o[h]),
            .resumeack_o          (resumeack_o[h]),
            .havereset_o          (havereset_o[h])
        );
    end

    assign sel_o       = (onehot | (hasel_i ? hawindow_i : '0)) & SelectableHarts;
    assign nonexistent = (hartsel_i >= NrHartsW);
    assign any_sel     = |sel_o;
    assign running     = ~halted_o & ~unavailable_i;

    // all* needs a non-empty selection, otherwise AND over nothing would read as 1
    assign status_o = {
        any_sel & (&(havereset_o   | ~sel_o)), |(havereset_o   & sel_o),
        any_sel & (&(resumeack_o   | ~sel_o)), |(resumeack_o   & sel_o),
        nonexistent & ~any_sel,                nonexistent,
        any_sel & (&(unavailable_i | ~sel_o)), |(unavailable_i & sel_o),
        any_sel & (&(running       | ~sel_o)), |(running       & sel_o),
        any_sel & (&(halted_o      | ~sel_o)), |(halted_o      & sel_o)
    };
endmodule

// File: tb/tb_dm_hart_status.sv
// Directed bench for dm_hart_status with 4 harts; hand-computed expectations.

module tb_dm_hart_status;
    logic        clk = 1'b0;
    logic        rst_ni, dmactive, ndmreset, hasel, we, hr_wd, rr_wd, ack_wd;
    logic        hv, rv;
    logic [1:0]  hid, rid;
    logic [3:0]  unavail, hawin;
    logic [19:0] hartsel;
    logic [3:0]  haltreq, resumereq, halted, resumeack, havereset, sel;
    logic [11:0] status;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dm_hart_status #(.NrHarts(4)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .dmactive_i(dmactive), .ndmreset_i(ndmreset),
        .unavailable_i(unavail), .hartsel_i(hartsel), .hasel_i(hasel), .hawindow_i(hawin),
        .dmcontrol_we_i(we), .haltreq_wdata_i(hr_wd), .resumereq_wdata_i(rr_wd),
        .ackhavereset_wdata_i(ack_wd), .halted_valid_i(hv), .halted_id_i(hid),
        .resuming_valid_i(rv), .resuming_id_i(rid), .haltreq_o(haltreq),
        .resumereq_o(resumereq), .halted_o(halted), .resumeack_o(resumeack),
        .havereset_o(havereset), .sel_o(sel), .status_o(status)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dm_write(input logic h, input logic r, input logic a);
        we = 1'b1; hr_wd = h; rr_wd = r; ack_wd = a;
        tick();
        we = 1'b0; hr_wd = 1'b0; rr_wd = 1'b0; ack_wd = 1'b0;
    endtask

    task automatic halt_ev(input logic [1:0] id);
        hv = 1'b1; hid = id;
        tick();
        hv = 1'b0;
    endtask

    task automatic resume_ev(input logic [1:0] id);
        rv = 1'b1; rid = id;
        tick();
        rv = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; dmactive = 1'b1; ndmreset = 1'b0; hasel = 1'b0; we = 1'b0;
        hr_wd = 1'b0; rr_wd = 1'b0; ack_wd = 1'b0; hv = 1'b0; rv = 1'b0; hid = '0; rid = '0;
        unavail = '0; hawin = '0; hartsel = '0;
        tick(); tick();
        rst_ni = 1'b1;
        tick();
        checks++; if (havereset !== 4'b1111) begin errors++; $display("FAIL reset_havereset got %b exp 1111", havereset); end
        checks++; if (halted !== 4'b0000) begin errors++; $display("FAIL reset_halted got %b exp 0000", halted); end
        checks++; if (haltreq !== 4'b0000 || resumereq !== 4'b0000 || resumeack !== 4'b0000) begin errors++; $display("FAIL reset_req got %b/%b/%b exp 0", haltreq, resumereq, resumeack); end
        checks++; if (sel !== 4'b0001) begin errors++; $display("FAIL reset_sel got %b exp 0001", sel); end
        checks++; if (status !== 12'hC0C) begin errors++; $display("FAIL reset_status got %h exp c0c", status); end
    endtask

    task automatic test_window();
        hasel = 1'b1; hawin = 4'b0110; hartsel = 20'd0;
        #1;
        checks++; if (sel !== 4'b0111) begin errors++; $display("FAIL win_sel got %b exp 0111", sel); end
        dm_write(1'b1, 1'b0, 1'b0);
        checks++; if (haltreq !== 4'b0111) begin errors++; $display("FAIL win_haltreq got %b exp 0111", haltreq); end
        halt_ev(2'd0); halt_ev(2'd1);
        checks++; if (status[3:0] !== 4'b0101) begin errors++; $display("FAIL win_partial got %b exp 0101", status[3:0]); end
        halt_ev(2'd2);
        checks++; if (halted !== 4'b0111 || status !== 12'hC03) begin errors++; $display("FAIL win_allhalted got %b/%h exp 0111/c03", halted, status); end
        dm_write(1'b0, 1'b1, 1'b0);
        checks++; if (resumereq !== 4'b0111 || resumeack !== 4'b0000 || haltreq !== 4'b0000) begin errors++; $display("FAIL win_resumereq got %b/%b/%b exp 0111/0000/0000", resumereq, resumeack, haltreq); end
        resume_ev(2'd0); resume_ev(2'd1);
        checks++; if (resumereq !== 4'b0100) begin errors++; $display("FAIL win_resumereq_hold got %b exp 0100", resumereq); end
        resume_ev(2'd2);
        checks++; if (resumereq !== 4'b0000 || resumeack !== 4'b0111 || status !== 12'hF0C) begin errors++; $display("FAIL win_resumed got %b/%b/%h exp 0000/0111/f0c", resumereq, resumeack, status); end
    endtask

    task automatic test_resume_running();
        hasel = 1'b0; hartsel = 20'd3;
        dm_write(1'b0, 1'b1, 1'b0);
        checks++; if (resumereq !== 4'b0000 || resumeack !== 4'b0111) begin errors++; $display("FAIL run_resume got %b/%b exp 0000/0111", resumereq, resumeack); end
    endtask

    task automatic test_simultaneous();
        hartsel = 20'd1;
        halt_ev(2'd1);
        dm_write(1'b0, 1'b1, 1'b0);
        checks++; if (resumereq !== 4'b0010 || resumeack !== 4'b0101) begin errors++; $display("FAIL sim_setup got %b/%b exp 0010/0101", resumereq, resumeack); end
        hv = 1'b1; hid = 2'd1; rv = 1'b1; rid = 2'd1;
        tick();
        hv = 1'b0; rv = 1'b0;
        checks++; if (halted !== 4'b0000 || resumeack !== 4'b0111 || resumereq !== 4'b0000) begin errors++; $display("FAIL sim_events got %b/%b/%b exp 0000/0111/0000", halted, resumeack, resumereq); end
    endtask

    task automatic test_nonexistent();
        hasel = 1'b0; hartsel = 20'd7;
        #1;
        checks++; if (sel !== 4'b0000 || status !== 12'h0C0) begin errors++; $display("FAIL nx_status got %b/%h exp 0000/0c0", sel, status); end
        dm_write(1'b1, 1'b0, 1'b1);
        checks++; if (haltreq !== 4'b0000 || havereset !== 4'b1111) begin errors++; $display("FAIL nx_write got %b/%b exp 0000/1111", haltreq, havereset); end
        halt_ev(2'd3);
        resume_ev(2'd3);
        checks++; if (halted !== 4'b0000 || resumeack !== 4'b1111) begin errors++; $display("FAIL nx_hart3 got %b/%b exp 0000/1111", halted, resumeack); end
    endtask

    task automatic test_ndmreset();
        hartsel = 20'd2;
        dm_write(1'b1, 1'b0, 1'b1);
        halt_ev(2'd2);
        checks++; if (haltreq !== 4'b0100 || havereset !== 4'b1011 || halted !== 4'b0100) begin errors++; $display("FAIL ndm_setup got %b/%b/%b exp 0100/1011/0100", haltreq, havereset, halted); end
        ndmreset = 1'b1; hv = 1'b1; hid = 2'd0;
        tick();
        ndmreset = 1'b0; hv = 1'b0;
        checks++; if (halted !== 4'b0000 || havereset !== 4'b1111 || haltreq !== 4'b0100 || resumeack !== 4'b0000) begin errors++; $display("FAIL ndm_pulse got %b/%b/%b/%b exp 0000/1111/0100/0000", halted, havereset, haltreq, resumeack); end
        dm_write(1'b1, 1'b0, 1'b1);
        checks++; if (havereset !== 4'b1011) begin errors++; $display("FAIL ndm_ack got %b exp 1011", havereset); end
    endtask

    task automatic test_dmactive();
        hartsel = 20'd0; unavail = 4'b0001;
        halt_ev(2'd0);
        checks++; if (status !== 12'hC33) begin errors++; $display("FAIL unavail_status got %h exp c33", status); end
        dmactive = 1'b0;
        dm_write(1'b1, 1'b0, 1'b1);
        dmactive = 1'b1; unavail = 4'b0000;
        checks++; if (haltreq !== 4'b0000 || halted !== 4'b0001 || havereset !== 4'b1011) begin errors++; $display("FAIL dmact_clear got %b/%b/%b exp 0000/0001/1011", haltreq, halted, havereset); end
    endtask

    task automatic test_back_to_back();
        hasel = 1'b1; hawin = 4'b1111; hartsel = 20'd0;
        dm_write(1'b1, 1'b0, 1'b0);
        dm_write(1'b0, 1'b1, 1'b0);
        checks++; if (haltreq !== 4'b0000 || resumereq !== 4'b0001) begin errors++; $display("FAIL b2b got %b/%b exp 0000/0001", haltreq, resumereq); end
        rst_ni = 1'b0; ndmreset = 1'b1;
        tick();
        rst_ni = 1'b1; ndmreset = 1'b0;
        checks++; if (havereset !== 4'b1111 || halted !== 4'b0000 || resumereq !== 4'b0000 || haltreq !== 4'b0000) begin errors++; $display("FAIL rerst got %b/%b/%b/%b exp 1111/0000/0000/0000", havereset, halted, resumereq, haltreq); end
    endtask

    initial begin
        test_reset();
        test_window();
        test_resume_running();
        test_simultaneous();
        test_nonexistent();
        test_ndmreset();
        test_dmactive();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
